// File: rtl/hammerblade_tb_sim_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hammerblade_tb_sim_ctrl
// Brief    : Simulation controller with reset-release pipeline, per-channel
//            activity counters, idle watchdog, cycle limit and drain-then-finish.
// Revision : 1.0 - initial release
// ============================================================================
module hammerblade_tb_sim_ctrl #(
    parameter int num_channels_p    = 4,
    parameter int reset_stages_p    = 3,
    parameter int ctr_width_p       = 32,
    parameter int event_ctr_width_p = 16,
    parameter int idle_timeout_p    = 10000,
    parameter int max_cycles_p      = 100000,
    parameter int drain_cycles_p    = 64
) (
    input  logic                                        clk_i,
    input  logic                                        reset_n_i,
    input  logic [num_channels_p-1:0]                   act_v_i,
    input  logic                                        finish_i,
    output logic                                        reset_o,
    output logic [ctr_width_p-1:0]                      global_ctr_o,
    output logic [num_channels_p*event_ctr_width_p-1:0] event_ctr_o,
    output logic [1:0]                                  state_o,
    output logic                                        done_o,
    output logic                                        timeout_o,
    output logic [1:0]                                  done_code_o
);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [1:0] c_code_none  = 2'd0;
    localparam logic [1:0] c_code_drain = 2'd1;
    localparam logic [1:0] c_code_idle  = 2'd2;
    localparam logic [1:0] c_code_max   = 2'd3;

    localparam logic                   c_max_en     = (max_cycles_p != 0);
    localparam logic                   c_idle_en    = (idle_timeout_p != 0);
    localparam logic [ctr_width_p-1:0] c_max_last   = ctr_width_p'(max_cycles_p - 1);
    localparam logic [ctr_width_p-1:0] c_idle_last  = ctr_width_p'(idle_timeout_p - 1);
    localparam logic [ctr_width_p-1:0] c_drain_last = ctr_width_p'(drain_cycles_p - 1);

    state_e                    r_state;
    state_e                    w_state_next;
    logic [1:0]                w_code_next;
    logic [reset_stages_p-1:0] r_rst_sr;
    logic                      r_reset;
    logic [ctr_width_p-1:0]    r_global_ctr;
    logic [ctr_width_p-1:0]    r_idle_ctr;
    logic [ctr_width_p-1:0]    r_drain_ctr;
    logic                      r_done;
    logic                      r_timeout;
    logic [1:0]                r_done_code;

    logic w_any_act;
    logic w_counting;
    logic w_limit_hit;
    logic w_idle_hit;
    logic w_drain_hit;

    assign w_any_act   = |act_v_i;
    assign w_counting  = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign w_limit_hit = c_max_en && (r_global_ctr == c_max_last);
    assign w_idle_hit  = c_idle_en && !w_any_act && (r_idle_ctr == c_idle_last);
    assign w_drain_hit = !w_any_act && (r_drain_ctr == c_drain_last);

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_code_next  = r_done_code;
        case (r_state)
            ST_RESET: begin
                // Move to RUN on the same edge that drops reset_o
                if (!r_rst_sr[reset_stages_p-1]) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_limit_hit) begin
                    w_state_next = ST_DONE;
                    w_code_next  = c_code_max;
                end else if (w_idle_hit) begin
                    w_state_next = ST_DONE;
                    w_code_next  = c_code_idle;
                end else if (finish_i) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_limit_hit) begin
                    w_state_next = ST_DONE;
                    w_code_next  = c_code_max;
                end else if (w_drain_hit) begin
                    w_state_next = ST_DONE;
                    w_code_next  = c_code_drain;
                end
            end
            default: begin
                w_state_next = ST_DONE;
            end
        endcase
    end

    // reset_o lags the pipeline MSB by one flop so it holds for exactly
    // reset_stages_p edges after release
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_rst_sr <= '1;
            r_reset  <= 1'b1;
        end else begin
            r_rst_sr <= r_rst_sr << 1;
            r_reset  <= r_rst_sr[reset_stages_p-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_global_ctr <= '0;
            r_idle_ctr   <= '0;
            r_drain_ctr  <= '0;
        end else begin
            if (w_counting) begin
                r_global_ctr <= r_global_ctr + 1'b1;
            end
            if (r_state == ST_RUN) begin
                r_idle_ctr  <= w_any_act ? '0 : r_idle_ctr + 1'b1;
                r_drain_ctr <= '0;
            end else if (r_state == ST_DRAIN) begin
                r_drain_ctr <= w_any_act ? '0 : r_drain_ctr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
            r_done_code <= c_code_none;
        end else begin
            r_done      <= (w_state_next == ST_DONE);
            r_timeout   <= (w_code_next == c_code_idle) || (w_code_next == c_code_max);
            r_done_code <= w_code_next;
        end
    end

    for (genvar g = 0; g < num_channels_p; g++) begin : g_chan
        logic [event_ctr_width_p-1:0] r_event_ctr;

        always_ff @(posedge clk_i) begin
            if (!reset_n_i) begin
                r_event_ctr <= '0;
            end else if (w_counting && act_v_i[g] && (r_event_ctr != '1)) begin
                r_event_ctr <= r_event_ctr + 1'b1;
            end
        end

        assign event_ctr_o[g*event_ctr_width_p +: event_ctr_width_p] = r_event_ctr;
    end

    assign reset_o      = r_reset;
    assign global_ctr_o = r_global_ctr;
    assign state_o      = r_state;
    assign done_o       = r_done;
    assign timeout_o    = r_timeout;
    assign done_code_o  = r_done_code;

endmodule
`default_nettype wire

// File: tb/tb_hammerblade_tb_sim_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hammerblade_tb_sim_ctrl
// Brief    : Scoreboard bench for the simulation controller against a
//            cycle-level reference model of its documented rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hammerblade_tb_sim_ctrl;

    localparam int NCH   = 4;
    localparam int S     = 3;
    localparam int CW    = 32;
    localparam int EW    = 4;
    localparam int IDLE  = 100;
    localparam int MAXC  = 1000;
    localparam int DRAIN = 64;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [NCH-1:0]    act_v = '0;
    logic              finish = 1'b0;
    logic              reset_o;
    logic [CW-1:0]     global_ctr_o;
    logic [NCH*EW-1:0] event_ctr_o;
    logic [1:0]        state_o;
    logic              done_o;
    logic              timeout_o;
    logic [1:0]        done_code_o;

    hammerblade_tb_sim_ctrl #(
        .num_channels_p    (NCH),
        .reset_stages_p    (S),
        .ctr_width_p       (CW),
        .event_ctr_width_p (EW),
        .idle_timeout_p    (IDLE),
        .max_cycles_p      (MAXC),
        .drain_cycles_p    (DRAIN)
    ) dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .act_v_i      (act_v),
        .finish_i     (finish),
        .reset_o      (reset_o),
        .global_ctr_o (global_ctr_o),
        .event_ctr_o  (event_ctr_o),
        .state_o      (state_o),
        .done_o       (done_o),
        .timeout_o    (timeout_o),
        .done_code_o  (done_code_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              rst;
        logic [CW-1:0]     gc;
        logic [NCH*EW-1:0] ev;
        logic [1:0]        st;
        logic              done;
        logic              tmo;
        logic [1:0]        code;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state: plain integers, updated once per clock edge
    int m_state, m_hi, m_gc, m_idle, m_drain, m_code;
    int m_ev[NCH];
    bit m_rst;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit rn, input bit [NCH-1:0] act, input bit fin);
        bit any;
        bit lim, idle_hit, drain_hit, go_drain;
        any = |act;
        if (!rn) begin
            m_state = 0; m_hi = 0; m_rst = 1'b1;
            m_gc = 0; m_idle = 0; m_drain = 0; m_code = 0;
            for (int c = 0; c < NCH; c++) m_ev[c] = 0;
        end else if (m_state == 0) begin
            m_hi++;
            m_rst = (m_hi <= S);
            if (!m_rst) m_state = 1;
        end else if (m_state == 1 || m_state == 2) begin
            lim       = (MAXC != 0) && (m_gc == MAXC - 1);
            idle_hit  = (m_state == 1) && (IDLE != 0) && !any && (m_idle == IDLE - 1);
            drain_hit = (m_state == 2) && !any && (m_drain == DRAIN - 1);
            go_drain  = (m_state == 1) && fin;
            m_gc++;
            for (int c = 0; c < NCH; c++)
                if (act[c] && m_ev[c] < (1 << EW) - 1) m_ev[c]++;
            m_idle  = any ? 0 : m_idle + 1;
            m_drain = (m_state == 1 || any) ? 0 : m_drain + 1;
            if (lim)            begin m_state = 3; m_code = 3; end
            else if (idle_hit)  begin m_state = 3; m_code = 2; end
            else if (drain_hit) begin m_state = 3; m_code = 1; end
            else if (go_drain)  m_state = 2;
        end
    endtask

    // Called at a falling edge: drive, predict the next edge, queue the prediction
    task automatic drive(input bit rn, input bit [NCH-1:0] act, input bit fin);
        exp_t e;
        reset_n = rn;
        act_v   = act;
        finish  = fin;
        model_step(rn, act, fin);
        e.rst  = m_rst;
        e.gc   = CW'(m_gc);
        for (int c = 0; c < NCH; c++) e.ev[c*EW +: EW] = EW'(m_ev[c]);
        e.st   = 2'(m_state);
        e.done = (m_state == 3);
        e.tmo  = (m_code >= 2);
        e.code = 2'(m_code);
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        repeat (n) drive(1'b0, '0, 1'b0);
    endtask

    task automatic release_to_run();
        repeat (S + 1) drive(1'b1, '0, 1'b0);
    endtask

    // Monitor: compare every presented output cycle with the queued prediction
    always begin
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("mon_reset_o", reset_o, mon_e.rst);
            chk("mon_global_ctr", global_ctr_o, mon_e.gc);
            chk("mon_event_ctr", event_ctr_o, mon_e.ev);
            chk("mon_state", state_o, mon_e.st);
            chk("mon_done", done_o, mon_e.done);
            chk("mon_timeout", timeout_o, mon_e.tmo);
            chk("mon_done_code", done_code_o, mon_e.code);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        bit       saw_drain;
        int       need0;
        bit       p0;
        bit [3:0] a;

        @(negedge clk);

        // Reset release timing
        do_reset(5);
        chk("reset_state_rst", reset_o, 1);
        chk("reset_state_st", state_o, 0);
        chk("reset_state_code", done_code_o, 0);
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, '0, 1'b0);
            chk("release_reset_o", reset_o, (k < S));
            chk("release_state", state_o, (k < S) ? 0 : 1);
        end
        chk("first_run_gc", global_ctr_o, 0);

        // Idle watchdog, no activity
        for (int i = 0; i < 300 && !done_o; i++) drive(1'b1, '0, 1'b0);
        chk("idle_done", done_o, 1);
        chk("idle_gc", global_ctr_o, 100);
        chk("idle_code", done_code_o, 2);
        chk("idle_timeout", timeout_o, 1);

        // Idle watchdog restarted by one ch1 pulse at count 60
        do_reset(2);
        release_to_run();
        for (int i = 0; i < 400 && !done_o; i++)
            drive(1'b1, (m_gc == 60) ? 4'b0010 : 4'b0000, 1'b0);
        chk("idle_pulse_done", done_o, 1);
        chk("idle_pulse_gc", global_ctr_o, 161);

        // Event counting with saturation, then a quiet drain
        do_reset(2);
        release_to_run();
        need0 = 10;
        for (int i = 0; i < 20; i++) begin
            p0 = (need0 > 0) && (($urandom % 2 == 1) || need0 >= 20 - i);
            if (p0) need0--;
            drive(1'b1, {1'b0, 1'b1, 1'b0, p0}, 1'b0);
        end
        chk("ev_ch0", event_ctr_o[0*EW +: EW], 10);
        chk("ev_ch1", event_ctr_o[1*EW +: EW], 0);
        chk("ev_ch2", event_ctr_o[2*EW +: EW], 15);
        chk("ev_ch3", event_ctr_o[3*EW +: EW], 0);
        drive(1'b1, '0, 1'b1);
        for (int i = 0; i < 200 && !done_o; i++) drive(1'b1, '0, 1'b0);
        chk("ev_drain_code", done_code_o, 1);

        // Finish/drain with ch3 activity inside DRAIN
        do_reset(2);
        release_to_run();
        for (int i = 0; i < 400 && !done_o; i++)
            drive(1'b1, (m_gc == 55 || m_gc == 70) ? 4'b1000 : 4'b0000, (m_gc == 50));
        chk("drain_done", done_o, 1);
        chk("drain_gc", global_ctr_o, 135);
        chk("drain_code", done_code_o, 1);
        chk("drain_timeout", timeout_o, 0);

        // Cycle limit takes priority over a finish request
        do_reset(2);
        release_to_run();
        saw_drain = 1'b0;
        for (int i = 0; i < 1100 && !done_o; i++) begin
            drive(1'b1, 4'b0001, (m_gc == 999));
            if (state_o == 2'd2) saw_drain = 1'b1;
        end
        chk("limit_done", done_o, 1);
        chk("limit_gc", global_ctr_o, 1000);
        chk("limit_code", done_code_o, 3);
        chk("limit_timeout", timeout_o, 1);
        chk("limit_no_drain", saw_drain, 0);

        // Reset in the middle of DRAIN, then a normal sequence
        do_reset(2);
        release_to_run();
        repeat (10) drive(1'b1, 4'($urandom), 1'b0);
        drive(1'b1, '0, 1'b1);
        repeat (5) drive(1'b1, 4'($urandom), 1'b0);
        chk("middrain_state", state_o, 2);
        drive(1'b0, '0, 1'b0);
        chk("middrain_rst_gc", global_ctr_o, 0);
        chk("middrain_rst_ev", event_ctr_o, 0);
        chk("middrain_rst_reset_o", reset_o, 1);
        chk("middrain_rst_state", state_o, 0);
        chk("middrain_rst_code", done_code_o, 0);
        release_to_run();
        repeat (20) drive(1'b1, '0, 1'b0);
        drive(1'b1, '0, 1'b1);
        for (int i = 0; i < 200 && !done_o; i++) drive(1'b1, '0, 1'b0);
        chk("rerun_gc", global_ctr_o, 85);
        chk("rerun_code", done_code_o, 1);

        // Randomised traffic, finishes and occasional resets
        for (int r = 0; r < 4; r++) begin
            do_reset($urandom_range(1, 3));
            for (int i = 0; i < 1200; i++) begin
                for (int j = 0; j < NCH; j++) a[j] = ($urandom % 24 == 0);
                drive(($urandom % 700) != 0, a, ($urandom % 150) == 0);
            end
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hammerblade_tb_sim_ctrl.md
# hammerblade_tb_sim_ctrl

Parametrised simulation-control block for manycore-level testbenches. It replaces the fixed reset-delay flops, free-running global cycle counter and hard `$finish` timer with one synthesizable-style controller. It provides a configurable reset-release pipeline, per-channel link activity counters, an idle watchdog, a hard cycle limit and a host-requested drain-then-finish sequence. The bench samples `done_o` and `done_code_o` to decide when and why to end simulation.

## Interface
Parameters:
- num_channels_p, 4: number of monitored link activity channels
- reset_stages_p, 3: cycles `reset_o` stays high after `reset_n_i` deasserts; must be >= 1
- ctr_width_p, 32: width of the global cycle counter
- event_ctr_width_p, 16: width of each per-channel event counter
- idle_timeout_p, 10000: consecutive all-idle RUN cycles before a watchdog stop; 0 disables
- max_cycles_p, 100000: hard limit on RUN+DRAIN cycles; 0 disables
- drain_cycles_p, 64: consecutive all-idle cycles required in DRAIN before finishing; must be >= 1

Ports:
- clk_i  in  1  sole clock
- reset_n_i  in  1  reset, synchronous, active-low
- act_v_i  in  num_channels_p  per-channel activity strobe (link valid&ready)
- finish_i  in  1  host finish request, level or pulse
- reset_o  out  1  delayed active-high reset for the DUT
- global_ctr_o  out  ctr_width_p  RUN+DRAIN cycle count
- event_ctr_o  out  num_channels_p*event_ctr_width_p  per-channel activity counts; channel i in slice [i*event_ctr_width_p +: event_ctr_width_p]
- state_o  out  2  0 RESET, 1 RUN, 2 DRAIN, 3 DONE
- done_o  out  1  sticky done
- timeout_o  out  1  done caused by watchdog or cycle limit
- done_code_o  out  2  0 none, 1 finish/drain, 2 idle timeout, 3 max cycles

## Operation
- **Reset (`reset_n_i`=0):**
  - All counters clear. The reset shift register fills with ones.
  - State is RESET. `reset_o`=1. `done_o`, `timeout_o` and `done_code_o` are 0. All counters read 0.
- **RESET state:**
  - A zero shifts into the reset pipeline each cycle.
  - `act_v_i` and `finish_i` are ignored.
  - RESET -> RUN in the cycle `reset_o` first reads 0.
- **RUN state:**
  - `global_ctr_o` increments by 1 each cycle.
  - Each channel counter increments when its `act_v_i` bit is high. All channels count independently in the same cycle. Counters saturate at all-ones.
  - The idle counter clears on any activity and increments otherwise.
- **Exit conditions, evaluated each RUN/DRAIN cycle, in priority order:**
  1. Cycle limit: `max_cycles_p`!=0 and `global_ctr_o`==`max_cycles_p`-1 -> DONE, code 3.
  2. Idle timeout (RUN only): `idle_timeout_p`!=0, no activity this cycle, and idle counter==`idle_timeout_p`-1 -> DONE, code 2.
  3. Finish (RUN only): `finish_i`=1 -> DRAIN.
- **DRAIN state:**
  - The global and event counters keep counting.
  - The drain counter clears on any activity and increments otherwise.
  - Drain counter==`drain_cycles_p`-1 with no activity -> DONE, code 1.
  - The cycle limit still applies and takes priority. The idle watchdog does not apply.
  - `finish_i` is ignored.
- **DONE state:**
  - Absorbing; only `reset_n_i` leaves it.
  - All counters freeze.
  - `done_o`=1. `timeout_o`=1 iff code is 2 or 3.
- Asserting `reset_n_i`=0 in any state, including mid-DRAIN, returns to full reset values on the next edge.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- **Reset release:** `reset_n_i` is first sampled high at edge E0. `reset_o` stays 1 through edge E0+`reset_stages_p`-1 and reads 0 after edge E0+`reset_stages_p`.
- **First RUN cycle:** `global_ctr_o`=0.
- **Event counters:** an `act_v_i` bit sampled at an edge is reflected in `event_ctr_o` after that edge.
- **Idle timeout:** with no activity from RUN entry, `done_o` rises when `global_ctr_o` reads `idle_timeout_p`.
- **Cycle limit:** `done_o` rises with `global_ctr_o`=`max_cycles_p`.
- **Drain:** `done_o` rises exactly `drain_cycles_p` cycles after the last active DRAIN cycle, or after DRAIN entry if there was no activity.
- **RUN -> DRAIN:** `state_o` reads 2 one cycle after `finish_i` is sampled.

## Test plan
- **Reset release:** `reset_stages_p`=3, hold `reset_n_i`=0 for 5 cycles, then release -> `reset_o`=1 for 3 edges after release, then 0. `state_o` goes 0->1. `global_ctr_o`=0 in the first RUN cycle.
- **Event counting and saturation:** `event_ctr_width_p`=4; pulse ch0 10 times and ch2 20 times, some pulses in the same cycle -> ch0=10, ch1=0, ch2=15 (saturated), ch3=0.
- **Idle watchdog:** `idle_timeout_p`=100, no activity -> `done_o`=1 with `global_ctr_o`=100, `done_code_o`=2, `timeout_o`=1. A single ch1 pulse at count 60 instead moves done to count 161.
- **Finish/drain:** `drain_cycles_p`=64; `finish_i` at count 50, ch3 activity at counts 55 and 70, then quiet -> done at count 135, code 1, `timeout_o`=0.
- **Cycle limit priority:** `max_cycles_p`=1000, continuous ch0 activity, `finish_i` high at count 999 -> DONE at 1000, code 3, `timeout_o`=1, state never reads 2.
- **Reset mid-DRAIN:** drive `reset_n_i`=0 for one cycle during DRAIN -> all counters 0, `reset_o`=1, `state_o`=0, `done_code_o`=0. The full sequence then repeats normally.
